// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle 4-register datapath with ROM fetch handshake and data memory.
// Define MC_DATAPATH_HALT_EN to park the core on a jump-to-self.
module mc_datapath #(
    parameter int DATA_W     = 8,
    parameter int PC_W       = 8,
    parameter int DMEM_DEPTH = 16
) (
    input  logic              _CLK,
    input  logic              _RESET,
    input  logic [7:0]        instruction,
    input  logic              ins_valid,
    output logic              fetch_req,
    output logic [PC_W-1:0]   PC,
    output logic              retire,
    output logic [DATA_W-1:0] datatowrite,
    output logic [6:0]        m,
    output logic [6:0]        l,
    output logic              halted
);
    localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB
    } state_t;

    state_t state, state_nx;

    logic [7:0]        ir;
    logic [DATA_W-1:0] opa, opb, alu, mdr;
    logic [DATA_W-1:0] regs [4];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];

    logic [1:0] op, rs, rt, rd;
    logic       is_add, is_sw, is_jmp;
    logic       park, halt_now;

    assign op     = ir[7:6];
    assign rs     = ir[5:4];
    assign rt     = ir[3:2];
    assign rd     = ir[1:0];
    assign is_add = (op == 2'b00);
    assign is_sw  = (op == 2'b10);
    assign is_jmp = (op == 2'b11);

    logic [DATA_W-1:0] imm_ext;
    logic [7:0]        jofs;
    logic [PC_W-1:0]   pc_inc, pc_jmp;
    logic [AW-1:0]     addr;

    assign imm_ext = {{(DATA_W-2){ir[1]}}, ir[1:0]};
    assign jofs    = {{2{ir[5]}}, ir[5:0]};
    assign pc_inc  = PC + PC_W'(1);
    assign pc_jmp  = pc_inc + jofs[PC_W-1:0];
    assign addr    = alu[AW-1:0];

`ifdef MC_DATAPATH_HALT_EN
    logic halt_q;

    assign halt_now = (state == EXEC) && is_jmp
                   && (ir[5:0] == 6'h3f);
    assign park     = halt_q;

    always_ff @(posedge _CLK or negedge _RESET) begin
        if (!_RESET) begin
            halt_q <= 1'b0;
        end else if (halt_now) begin
            halt_q <= 1'b1;
        end
    end
`else
    assign halt_now = 1'b0;
    assign park     = 1'b0;
`endif

    assign halted = park | halt_now;

    always_comb begin
        state_nx  = state;
        retire    = 1'b0;
        fetch_req = 1'b0;
        unique case (state)
            FETCH: begin
                fetch_req = !park;
                if (ins_valid && !park) state_nx = DECODE;
            end
            DECODE: state_nx = EXEC;
            EXEC: begin
                if (is_jmp) begin
                    retire   = 1'b1;
                    state_nx = FETCH;
                end else if (is_add) begin
                    state_nx = WB;
                end else begin
                    state_nx = MEM;
                end
            end
            MEM: begin
                if (is_sw) begin
                    retire   = 1'b1;
                    state_nx = FETCH;
                end else begin
                    state_nx = WB;
                end
            end
            WB: begin
                retire   = 1'b1;
                state_nx = FETCH;
            end
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge _CLK or negedge _RESET) begin
        if (!_RESET) begin
            state       <= FETCH;
            PC          <= '0;
            ir          <= '0;
            opa         <= '0;
            opb         <= '0;
            alu         <= '0;
            mdr         <= '0;
            datatowrite <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            state <= state_nx;
            case (state)
                FETCH: if (ins_valid && !park) ir <= instruction;
                DECODE: begin
                    opa <= regs[rs];
                    opb <= regs[rt];
                end
                EXEC: begin
                    alu <= opa + (is_add ? opb : imm_ext);
                    if (is_jmp) PC <= pc_jmp;
                end
                MEM: begin
                    if (is_sw) begin
                        datatowrite <= opb;
                        PC          <= pc_inc;
                    end else begin
                        mdr <= dmem[addr];
                    end
                end
                WB: begin
                    if (is_add) begin
                        regs[rd]    <= alu;
                        datatowrite <= alu;
                    end else begin
                        regs[rt]    <= mdr;
                        datatowrite <= mdr;
                    end
                    PC <= pc_inc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge _CLK or negedge _RESET) begin
        if (!_RESET) begin
            for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
        end else if (state == MEM && is_sw) begin
            dmem[addr] <= opb;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'ha: seg7 = 7'b0001000;
            4'hb: seg7 = 7'b0000011;
            4'hc: seg7 = 7'b1000110;
            4'hd: seg7 = 7'b0100001;
            4'he: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Display always shows the low byte, whatever DATA_W is.
    assign m = seg7(datatowrite[7:4]);
    assign l = seg7(datatowrite[3:0]);
endmodule
